// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Pure definitions: no latency, no backpressure.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_decode_pipe.sv
// IF/ID pipeline register: one cycle from deliver_i to outputs.
// Priority rst > flush (bubble) > stall (hold) > deliver > bubble.
module fetch_decode_pipe
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  deliver_i,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [31:0]           instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o
);

  logic [31:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  vld_q, vld_d;

  always_comb begin
    instr_d = NOP_INSTR;
    pc_d    = '0;
    pc4_d   = '0;
    vld_d   = 1'b0;
    if (flush_i) begin
      instr_d = NOP_INSTR;
    end else if (stall_i) begin
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      vld_d   = vld_q;
    end else if (deliver_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      pc4_d   = pc_i + DATA_WIDTH'(4);
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      vld_q   <= vld_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = vld_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one outstanding imem read, hold buffer, redirect; accept N, rvalid N+k, InstrD N+k+1.
// StallF parks returned data in the hold buffer; imem_ready backpressures the request in REQ.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           InstrD,
  output logic [DATA_WIDTH-1:0] PCounterD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
  logic [31:0]           hold_instr_q, hold_instr_d;
  logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                  hold_vld_q, hold_vld_d;

  logic                  deliver;
  logic [31:0]           deliver_instr;
  logic [DATA_WIDTH-1:0] deliver_pc;
  logic [DATA_WIDTH-1:0] pcf_plus4;
  logic [DATA_WIDTH-1:0] redirect_pc;

  assign pcf_plus4   = pcf_q + DATA_WIDTH'(4);
  assign redirect_pc = PCTargetE & ~DATA_WIDTH'(3);
  assign imem_req    = (state_q == REQ) && !rst;
  assign imem_addr   = pcf_q;

  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    hold_vld_d    = hold_vld_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = pcf_q;
    case (state_q)
      REQ: begin
        if (imem_ready) state_d = PCSrcE ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (PCSrcE) begin
            state_d = REQ;
          end else if (!StallF) begin
            deliver = 1'b1;
            pcf_d   = pcf_plus4;
            state_d = REQ;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pcf_q;
            hold_vld_d   = 1'b1;
            state_d      = HOLD;
          end
        end else if (PCSrcE) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          hold_vld_d = 1'b0;
          state_d    = REQ;
        end else if (!StallF && hold_vld_q) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc    = hold_pc_q;
          pcf_d         = pcf_plus4;
          hold_vld_d    = 1'b0;
          state_d       = REQ;
        end
      end
      DROP: begin
        // The abandoned response retires the outstanding request, redirect or not.
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    if (PCSrcE) pcf_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      pcf_q        <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      hold_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_vld_q   <= hold_vld_d;
    end
  end

  fetch_decode_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (StallF),
    .flush_i   (FlushD),
    .deliver_i (deliver),
    .instr_i   (deliver_instr),
    .pc_i      (deliver_pc),
    .instr_o   (InstrD),
    .pc_o      (PCounterD),
    .pc_plus4_o(PCPlus4D),
    .valid_o   (ValidD)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural imem with latency k feeds a scoreboard of expected IF/ID deliveries.
// Directed phases cover streaming, stall/hold, redirects, flush, PC wrap and reset mid-request.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int          DW     = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, StallF, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCounterD, PCPlus4D;
  logic        ValidD;

  instr_fetch_unit #(
    .DATA_WIDTH(DW),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCounterD  (PCounterD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_k    = 1;
  logic        push_en  = 1'b1;
  logic        ovr_en   = 1'b0;
  logic [31:0] ovr_dat  = 32'h0;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: sample handshake before the edge, then update the memory model and check IF/ID.
  task automatic step();
    logic        acc, prev_stall;
    logic [31:0] acc_addr, d;
    exp_t        e;
    #1;
    acc        = imem_req && imem_ready;
    acc_addr   = imem_addr;
    prev_stall = StallF && !FlushD && !rst;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_cnt  = mem_k;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        d           = ovr_en ? ovr_dat : mem_word(pend_addr);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        pend        = 1'b0;
        if (push_en) sb.push_back('{instr: d, pc: pend_addr});
      end
    end
    if (ValidD) begin
      if (!prev_stall) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", ValidD, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", {InstrD, PCounterD, PCPlus4D}, {e.instr, e.pc, e.pc + 32'd4});
        end
      end
    end else begin
      chk("bubble", {InstrD, PCounterD, PCPlus4D}, {NOP_INSTR, 64'h0});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    step(); step();
    chk("rst_valid", ValidD, 1'b0);
    chk("rst_instr", InstrD, NOP_INSTR);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_state", dut.state_q, REQ);

    // Streaming, ready=1, k=1: one instruction every other cycle.
    imem_ready = 1'b1; rst = 1'b0;
    #1;
    for (int i = 0; i <= 6; i++) begin
      if (i % 2 == 0) begin
        chk("t1_req", imem_req, 1'b1);
        chk("t1_addr", imem_addr, 32'(i * 2));
      end else begin
        chk("t1_noreq", imem_req, 1'b0);
      end
      chk("t1_valid", ValidD, (i >= 2 && i % 2 == 0));
      if (i < 6) step();
    end

    // Stall for 3 cycles while 0xDEADBEEF returns.
    StallF = 1'b1; ovr_en = 1'b1; ovr_dat = 32'hDEAD_BEEF;
    step();
    ovr_en = 1'b0; imem_ready = 1'b0;
    chk("t2_hold0", {ValidD, InstrD}, {1'b1, mem_word(32'h8)});
    step();
    chk("t2_state", dut.state_q, HOLD);
    chk("t2_hold1", {ValidD, InstrD}, {1'b1, mem_word(32'h8)});
    step();
    chk("t2_hold2", {ValidD, InstrD}, {1'b1, mem_word(32'h8)});
    chk("t2_noreq", imem_req, 1'b0);
    StallF = 1'b0;
    step();
    chk("t2_instr", {ValidD, InstrD}, {1'b1, 32'hDEAD_BEEF});
    chk("t2_pc", imem_addr, 32'h10);
    step(); step();
    chk("t2_pc_once", imem_addr, 32'h10);

    // Redirect while waiting with k=3: stale data dropped.
    mem_k = 3; imem_ready = 1'b1; push_en = 1'b0;
    step();
    imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h103;
    chk("t3_wait", dut.state_q, WAIT);
    step();
    PCSrcE = 1'b0;
    chk("t3_drop", dut.state_q, DROP);
    chk("t3_noreq", imem_req, 1'b0);
    step();
    chk("t3_drop2", {dut.state_q, imem_addr}, {DROP, 32'h100});
    step();
    push_en = 1'b1;
    chk("t3_addr", {imem_req, imem_addr}, {1'b1, 32'h100});
    chk("t3_valid", ValidD, 1'b0);

    // Redirect coinciding with rvalid.
    mem_k = 1; imem_ready = 1'b1; push_en = 1'b0;
    step();
    imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h200;
    step();
    PCSrcE = 1'b0; push_en = 1'b1;
    chk("t4_addr", {imem_req, imem_addr}, {1'b1, 32'h200});
    chk("t4_valid", ValidD, 1'b0);
    step();
    chk("t4_valid2", ValidD, 1'b0);
    chk("t4_state", dut.state_q, REQ);

    // Flush together with stall: bubble wins, hold buffer survives.
    imem_ready = 1'b1;
    step();
    step();
    chk("t5_v", {ValidD, InstrD}, {1'b1, mem_word(32'h200)});
    step();
    imem_ready = 1'b0; StallF = 1'b1; FlushD = 1'b1;
    step();
    chk("t5_flush", {ValidD, InstrD}, {1'b0, NOP_INSTR});
    chk("t5_state", dut.state_q, HOLD);
    FlushD = 1'b0;
    step();
    chk("t5_hold", ValidD, 1'b0);
    StallF = 1'b0;
    step();
    chk("t5_buf", {ValidD, PCounterD}, {1'b1, 32'h204});
    chk("t5_addr", imem_addr, 32'h208);

    // PC wrap from 0xFFFFFFFC.
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0;
    chk("t5b_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    chk("t5b_wrap", imem_addr, 32'h0);
    chk("t5b_pc4", {PCounterD, PCPlus4D}, {32'hFFFF_FFFC, 32'h0});

    // Reset while waiting, then a late rvalid.
    PCSrcE = 1'b1; PCTargetE = 32'h300;
    step();
    PCSrcE = 1'b0;
    mem_k = 3; imem_ready = 1'b1; push_en = 1'b0;
    step();
    imem_ready = 1'b0; rst = 1'b1;
    #1;
    chk("t6_rst_req", imem_req, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_addr", {imem_req, imem_addr}, {1'b1, RST_PC});
    step();
    step();
    chk("t6_state", dut.state_q, REQ);
    chk("t6_valid", ValidD, 1'b0);
    push_en = 1'b1; mem_k = 1; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    chk("t6_first", {ValidD, PCounterD}, {1'b1, RST_PC});

    step(); step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the pipelined RISC-V core: owns the program counter, issues single-outstanding reads to the instruction memory over a request/response handshake, and drives the IF/ID pipeline register that feeds the decode stage, which in turn feeds `decode_execute_pipe`. It handles multi-cycle memory latency, hazard-unit stalls (with a one-entry hold buffer), decode flushes and taken-branch redirects from execute.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC and addresses
- `RESET_PC`, 32'h0000_0000, PC loaded on reset

Ports:
- `clk`  input  1  clock
- `rst`  input  1  reset; one clock, synchronous, active-high
- `StallF`  input  1  hazard unit: hold PC and IF/ID register
- `FlushD`  input  1  hazard unit: replace IF/ID contents with a bubble
- `PCSrcE`  input  1  execute: taken branch/jump, redirect fetch
- `PCTargetE`  input  DATA_WIDTH  redirect target
- `imem_req`  output  1  request valid
- `imem_addr`  output  DATA_WIDTH  request address (= PCF)
- `imem_ready`  input  1  memory accepts request this cycle
- `imem_rvalid`  input  1  read data valid
- `imem_rdata`  input  32  instruction word
- `InstrD`  output  32  instruction to decode
- `PCounterD`  output  DATA_WIDTH  PC of `InstrD`
- `PCPlus4D`  output  DATA_WIDTH  `PCounterD` + 4
- `ValidD`  output  1  `InstrD` is a real instruction, not a bubble

## Operation
- States: REQ, WAIT, HOLD, DROP. At most one outstanding request.
- REQ: `imem_req`=1, `imem_addr`=PCF. `imem_ready` → WAIT. Address may change while not yet accepted.
- WAIT: on `imem_rvalid`:
  - `StallF`=0: load IF/ID {rdata, PCF, PCF+4, ValidD=1}; PCF ← PCF+4; → REQ.
  - `StallF`=1: capture {rdata, PCF} in hold buffer; → HOLD.
- HOLD: on `StallF`=0, load IF/ID from the buffer; PCF ← PCF+4; → REQ.
- DROP: wait for `imem_rvalid`, discard the data, → REQ.
- Redirect (`PCSrcE`=1) overrides all other PC updates: PCF ← {PCTargetE[DW-1:2],2'b00}. Next state:
  - REQ, no ready: stays REQ.
  - REQ with `imem_ready`: DROP.
  - WAIT without rvalid: DROP.
  - WAIT with rvalid: data discarded, → REQ.
  - HOLD: buffer discarded, → REQ.
  - DROP: stays DROP.
  - Redirect data is never loaded into IF/ID.
- IF/ID register priority: `rst` > `FlushD` > `StallF` (hold) > deliver > bubble.
- Bubble: `InstrD`=32'h0000_0013 (NOP), `ValidD`=0, `PCounterD`=0, `PCPlus4D`=0. A bubble is written in every non-stalled cycle with no delivery.
- PC arithmetic is modulo 2^DATA_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: PCF=RESET_PC, state=REQ, hold buffer invalid, `InstrD`=NOP, `ValidD`=0, `PCounterD`=0, `PCPlus4D`=0.
- `imem_req`=0 in every cycle `rst` is high. The first request is issued in the first cycle after `rst` falls.
- Reset asserted mid-request: the state returns to REQ. Any later `imem_rvalid` from the abandoned request is ignored, because the state is REQ, not WAIT.
- Latency: request accepted in cycle N, `imem_rvalid` in N+k (k≥1), `InstrD` visible at N+k+1.
- Peak throughput: one instruction per 2 cycles with k=1.
- `imem_addr`, `imem_req` are combinational from the state and PCF. All other outputs are registered.
- `FlushD` and `StallF` in the same cycle: the flush wins and a bubble is written. The hold buffer is unaffected.

## Structure
- Package `fetch_pkg`: `NOP_INSTR` constant, `fetch_state_t` enum {REQ, WAIT, HOLD, DROP}.
- Sub-module `fetch_decode_pipe`: the IF/ID register with stall/flush/bubble priority.
- `instr_fetch_unit` contains the FSM, PCF and the hold buffer.

## Test plan
- Reset release, memory with ready=1 and k=1: requests to 0x0, 0x4, 0x8. `InstrD` follows with `ValidD`=1 on every second cycle and bubbles in between; `PCPlus4D`=0x4, 0x8, 0xC.
- `StallF` held 3 cycles while data 0xDEADBEEF returns: FSM enters HOLD and `InstrD` is unchanged. After release, `InstrD`=0xDEADBEEF and PCF advances by 4 exactly once.
- `PCSrcE`=1 with target 0x100 while in WAIT (k=3): FSM enters DROP, the stale data never reaches `InstrD`, and the next `imem_addr`=0x100.
- `PCSrcE` and `imem_rvalid` in the same cycle: the data is discarded, the next request goes to the target, and `ValidD` stays 0.
- `FlushD` with `StallF`: `InstrD`=0x00000013, `ValidD`=0. Second case: PCF=0xFFFFFFFC delivers, after which PCF=0x0.
- `rst` asserted in WAIT, then a late `imem_rvalid`: the data is ignored and the first post-reset request goes to `RESET_PC`.
